// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and constants for the double-buffered row frame store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_buffer_ctrl_pkg;

    localparam int NCOLS      = 32;
    localparam int NROWS      = 16;
    localparam int CLR_CYCLES = NROWS;
    localparam int ROW_W      = 4;

    typedef logic [NCOLS-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SWAP_PEND,
        SWAP
    } state_t;

endpackage

// File: rtl/frame_buffer_ctrl_bank.sv
// One NROWS x NCOLS bit buffer: write port, synchronous row-clear port, combinational read port.
// Latency: writes/clears land on the next rising edge; read is combinational.
// Backpressure: none; the caller gates we/clr.
module fb_bank #(
    parameter int NCOLS = 32,
    parameter int NROWS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       wrow,
    input  logic [NCOLS-1:0] wdata,
    input  logic             clr,
    input  logic [3:0]       crow,
    input  logic [3:0]       rrow,
    output logic [NCOLS-1:0] rdata
);

    logic [NCOLS-1:0] mem [NROWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NROWS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            mem[crow] <= '0;
        end else if (we) begin
            mem[wrow] <= wdata;
        end
    end

    assign rdata = mem[rrow];

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered panel frame store: writer fills the back buffer, swaps align to frame_done.
// Latency: rd_data is 1 cycle after rd_row; swap_ack/front_sel change 1 cycle after frame_done.
// Backpressure: wr_ready drops while clearing, while a swap is pending, and when clr/swap is requested.
module frame_buffer_ctrl #(
    parameter int NCOLS = 32,
    parameter int NROWS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_row,
    input  logic [NCOLS-1:0] wr_data,
    input  logic             clr_req,
    input  logic             swap_req,
    output logic             swap_ack,
    input  logic             frame_done,
    input  logic [3:0]       rd_row,
    output logic [NCOLS-1:0] rd_data,
    output logic             front_sel,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    import frame_buffer_ctrl_pkg::*;

    localparam logic [3:0] CLR_LAST = 4'(NROWS - 1);

    state_t           state;
    logic [3:0]       clr_row;
    logic             wr_acc;
    logic             clearing;
    logic [NCOLS-1:0] rdata0;
    logic [NCOLS-1:0] rdata1;

    // Control requests outrank a write presented in the same cycle.
    assign wr_ready = (state == IDLE) && !clr_req && !swap_req;
    assign wr_acc   = wr_valid && wr_ready;
    assign busy     = (state != IDLE);
    assign clearing = (state == CLEAR);

    // Bank b is the back buffer whenever front_sel != b.
    fb_bank #(.NCOLS(NCOLS), .NROWS(NROWS)) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc && front_sel),
        .wrow  (wr_row),
        .wdata (wr_data),
        .clr   (clearing && front_sel),
        .crow  (clr_row),
        .rrow  (rd_row),
        .rdata (rdata0)
    );

    fb_bank #(.NCOLS(NCOLS), .NROWS(NROWS)) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc && !front_sel),
        .wrow  (wr_row),
        .wdata (wr_data),
        .clr   (clearing && !front_sel),
        .crow  (clr_row),
        .rrow  (rd_row),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
            frame_cnt <= '0;
            clr_row   <= '0;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_row <= '0;
                    end else if (swap_req) begin
                        state <= SWAP_PEND;
                    end
                end
                CLEAR: begin
                    clr_row <= clr_row + 4'd1;
                    if (clr_row == CLR_LAST) begin
                        state <= IDLE;
                    end
                end
                // Committed once entered: a dropped swap_req does not cancel.
                SWAP_PEND: begin
                    if (frame_done) begin
                        state     <= SWAP;
                        front_sel <= !front_sel;
                        swap_ack  <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                SWAP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Uses the pre-edge front_sel, so a read sampled on the toggle edge returns the old front.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= front_sel ? rdata1 : rdata0;
        end
    end

endmodule
